// File: rtl/dir_rom_scanner.sv
// dir_rom_scanner
// Sweeps the 256 positions of the 16x16 descriptor window through the
// direction-offset ROM pair, adds the rotated offsets to the latched keypoint
// and streams image-clamped absolute coordinates over a valid/ready handshake.
module dir_rom_scanner #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int COORD_W = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_kp_x,
    input  logic [COORD_W-1:0] i_kp_y,
    output logic               o_busy,
    output logic [7:0]         o_rom_a,
    input  logic [4:0]         i_rom_dx,
    input  logic [4:0]         i_rom_dy,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [7:0]         o_out_idx,
    output logic [COORD_W-1:0] o_out_x,
    output logic [COORD_W-1:0] o_out_y,
    output logic               o_out_oob,
    output logic               o_out_last,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Signed limits one bit wider than a coordinate plus a sign bit, so the
    // sum of a full-range keypoint and a negative offset never wraps.
    localparam logic signed [COORD_W+1:0] LIM_X = (COORD_W+2)'(IMG_W);
    localparam logic signed [COORD_W+1:0] LIM_Y = (COORD_W+2)'(IMG_H);
    localparam logic [COORD_W-1:0]        MAX_X = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0]        MAX_Y = COORD_W'(IMG_H - 1);

    // Returns {out_of_bounds, clamped_coordinate} for one axis.
    function automatic logic [COORD_W:0] clamp_axis(
        input logic [COORD_W-1:0]        kp,
        input logic [4:0]                off,
        input logic signed [COORD_W+1:0] lim,
        input logic [COORD_W-1:0]        max_v
    );
        logic signed [COORD_W+1:0] sum;
        sum = $signed({2'b00, kp}) + $signed({{(COORD_W-3){off[4]}}, off});
        if (sum[COORD_W+1]) begin
            clamp_axis = {1'b1, {COORD_W{1'b0}}};
        end else if (sum >= lim) begin
            clamp_axis = {1'b1, max_v};
        end else begin
            clamp_axis = {1'b0, sum[COORD_W-1:0]};
        end
    endfunction

    state_t             r_state;
    logic               r_busy;
    logic [COORD_W-1:0] r_kp_x;
    logic [COORD_W-1:0] r_kp_y;
    logic [7:0]         r_idx;
    logic               r_out_valid;
    logic [7:0]         r_out_idx;
    logic [COORD_W-1:0] r_out_x;
    logic [COORD_W-1:0] r_out_y;
    logic               r_out_oob;
    logic               r_out_last;
    logic               r_done;

    logic [COORD_W:0]   w_cx;
    logic [COORD_W:0]   w_cy;
    logic               w_slot_free;

    // The ROM is read combinationally from the registered address, so the
    // clamp results belong to the index currently held in r_idx.
    assign w_cx        = clamp_axis(r_kp_x, i_rom_dx, LIM_X, MAX_X);
    assign w_cy        = clamp_axis(r_kp_y, i_rom_dy, LIM_Y, MAX_Y);
    assign w_slot_free = ~r_out_valid | i_out_ready;

    // Scan sequencer, ROM address and output register in one state machine.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_kp_x      <= {COORD_W{1'b0}};
            r_kp_y      <= {COORD_W{1'b0}};
            r_idx       <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 8'd0;
            r_out_x     <= {COORD_W{1'b0}};
            r_out_y     <= {COORD_W{1'b0}};
            r_out_oob   <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_kp_x  <= i_kp_x;
                        r_kp_y  <= i_kp_y;
                        r_idx   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_idx   <= r_idx;
                        r_out_x     <= w_cx[COORD_W-1:0];
                        r_out_y     <= w_cy[COORD_W-1:0];
                        r_out_oob   <= w_cx[COORD_W] | w_cy[COORD_W];
                        r_out_last  <= (r_idx == 8'd255);
                        if (r_idx == 8'd255) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end else begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_DRAIN: begin
                    // Index 255 is waiting in the output register; finish
                    // once it is taken. The address returns to 0 for IDLE.
                    if (r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_idx       <= 8'd0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_idx       <= 8'd0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_rom_a     = r_idx;
    assign o_out_valid = r_out_valid;
    assign o_out_idx   = r_out_idx;
    assign o_out_x     = r_out_x;
    assign o_out_y     = r_out_y;
    assign o_out_oob   = r_out_oob;
    assign o_out_last  = r_out_last;
    assign o_done      = r_done;

endmodule

// File: tb/tb_dir_rom_scanner.sv
// Self-checking bench for dir_rom_scanner: random ROM contents and keypoints,
// expected samples computed from the clamping rules with integer arithmetic.
module tb_dir_rom_scanner;

    localparam int IMG_W   = 640;
    localparam int IMG_H   = 480;
    localparam int COORD_W = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [COORD_W-1:0] kp_x;
    logic [COORD_W-1:0] kp_y;
    logic               busy;
    logic [7:0]         rom_a;
    logic [4:0]         rom_dx;
    logic [4:0]         rom_dy;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_idx;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic               out_oob;
    logic               out_last;
    logic               done;

    logic [4:0] rom_x [256];
    logic [4:0] rom_y [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rom_dx = rom_x[rom_a];
    assign rom_dy = rom_y[rom_a];

    dir_rom_scanner #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_kp_x      (kp_x),
        .i_kp_y      (kp_y),
        .o_busy      (busy),
        .o_rom_a     (rom_a),
        .i_rom_dx    (rom_dx),
        .i_rom_dy    (rom_dy),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_idx   (out_idx),
        .o_out_x     (out_x),
        .o_out_y     (out_y),
        .o_out_oob   (out_oob),
        .o_out_last  (out_last),
        .o_done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int off5(input logic [4:0] v);
        return v[4] ? int'(v) - 32 : int'(v);
    endfunction

    // Random table with the directed entries used by the clamp scenarios.
    task automatic fill_rom();
        for (int i = 0; i < 256; i++) begin
            rom_x[i] = 5'($urandom_range(0, 31));
            rom_y[i] = 5'($urandom_range(0, 31));
        end
        rom_x[0]  = 5'd2;
        rom_y[0]  = 5'd3;
        rom_y[64] = 5'h1F;
    endtask

    // mode 0: ready held high; 1: 5-cycle stall on idx 10;
    // 2: random ready plus a start pulse while busy; 3: reset near idx 100.
    task automatic run_scan(input int kx, input int ky, input int mode);
        int ex [256];
        int ey [256];
        int eo [256];
        int sx, sy, next_exp, done_cnt, done_cyc, cyc, hold;
        bit finished, aborted, stalled;
        fill_rom();
        for (int i = 0; i < 256; i++) begin
            sx = kx + off5(rom_x[i]);
            sy = ky + off5(rom_y[i]);
            eo[i] = (sx < 0 || sx >= IMG_W || sy < 0 || sy >= IMG_H) ? 1 : 0;
            ex[i] = (sx < 0) ? 0 : ((sx >= IMG_W) ? IMG_W - 1 : sx);
            ey[i] = (sy < 0) ? 0 : ((sy >= IMG_H) ? IMG_H - 1 : sy);
        end
        @(posedge clk); #1;
        start = 1'b1;
        kp_x = COORD_W'(kx);
        kp_y = COORD_W'(ky);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kp_x = COORD_W'($urandom_range(0, 639));
        kp_y = COORD_W'($urandom_range(0, 479));
        next_exp = 0; done_cnt = 0; done_cyc = 0; cyc = 0; hold = 0;
        finished = 1'b0; aborted = 1'b0; stalled = 1'b0;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_val("first_busy", 32'(busy), 32'd1);
                check_val("first_rom_a", 32'(rom_a), 32'd0);
                check_val("first_valid", 32'(out_valid), 32'd0);
            end
            if (cyc == 2) check_val("latency_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                check_val("idx", 32'(out_idx), 32'(next_exp));
                if (next_exp < 256) begin
                    check_val("x", 32'(out_x), 32'(ex[next_exp]));
                    check_val("y", 32'(out_y), 32'(ey[next_exp]));
                    check_val("oob", 32'(out_oob), 32'(eo[next_exp]));
                    check_val("last", 32'(out_last), (next_exp == 255) ? 32'd1 : 32'd0);
                    if (next_exp < 255) check_val("rom_a_ahead", 32'(rom_a), 32'(next_exp + 1));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_val("done_after_last", 32'(next_exp), 32'd256);
                check_val("busy_low_with_done", 32'(busy), 32'd0);
                finished = 1'b1;
            end
            if (out_valid && out_ready) next_exp++;
            if (mode == 1 && !stalled && out_valid && out_ready && out_idx == 8'd9) begin
                stalled = 1'b1;
                hold = 5;
            end
            if (mode == 3 && out_valid && out_idx == 8'd100) begin
                aborted = 1'b1;
                finished = 1'b1;
            end
            if (cyc > 3000) begin
                check_val("timeout", 32'd0, 32'd1);
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                if (mode == 2) begin
                    out_ready = 1'($urandom_range(0, 1));
                    start = (cyc == 40);
                end else if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_val("abort_busy", 32'(busy), 32'd0);
                check_val("abort_valid", 32'(out_valid), 32'd0);
                check_val("abort_rom_a", 32'(rom_a), 32'd0);
                check_val("abort_done", 32'(done), 32'd0);
            end
        end else begin
            check_val("done_count", 32'(done_cnt), 32'd1);
            check_val("handshakes", 32'(next_exp), 32'd256);
            if (mode == 0) check_val("scan_cycles", 32'(done_cyc), 32'd258);
            if (mode == 1) check_val("stall_seen", 32'(stalled), 32'd1);
            @(negedge clk);
            check_val("no_second_done", 32'(done), 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        kp_x = '0;
        kp_y = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom_x[i] = 5'd0;
            rom_y[i] = 5'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rom_a", 32'(rom_a), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_idx", 32'(out_idx), 32'd0);
        check_val("rst_x", 32'(out_x), 32'd0);
        check_val("rst_y", 32'(out_y), 32'd0);
        check_val("rst_oob", 32'(out_oob), 32'd0);
        check_val("rst_last", 32'(out_last), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);

        run_scan(100, 50, 0);
        run_scan(300, 0, 1);
        run_scan(639, 479, 2);
        run_scan(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 3);
        run_scan(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0);
        run_scan(0, 479, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
